fetch_sequencer: RTL

- Instruction-side counterpart of the control unit in the multi-cycle CPU.
- Owns the PC, fetches instruction words from instruction memory through a req/ack handshake, and presents the word and its decoded fields (opcode, funct, rs, rt) to the decoder.
- Consumes the decoder's 4-bit branch code plus the register operands when execute completes, then resolves the next PC.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/fetch_sequencer_if.sv | 17 +
 rtl/fetch_sequencer_branch_resolve.sv | 64 ++++++
 rtl/fetch_sequencer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg : branch codes, fetch FSM encoding and reset PC shared by the CPU.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

  // Branch codes as emitted by the decoder
  localparam logic [3:0] BR_NONE   = 4'd0;
  localparam logic [3:0] BR_JR     = 4'd1;
  localparam logic [3:0] BR_J      = 4'd2;
  localparam logic [3:0] BR_JAL    = 4'd3;
  localparam logic [3:0] BR_BAL    = 4'd4;
  localparam logic [3:0] BR_BGEZAL = 4'd5;
  localparam logic [3:0] BR_BLTZ   = 4'd6;
  localparam logic [3:0] BR_BGEZ   = 4'd7;
  localparam logic [3:0] BR_BLTZAL = 4'd8;
  localparam logic [3:0] BR_B      = 4'd9;
  localparam logic [3:0] BR_BEQ    = 4'd10;
  localparam logic [3:0] BR_BNE    = 4'd11;
  localparam logic [3:0] BR_BLEZ   = 4'd12;
  localparam logic [3:0] BR_BGTZ   = 4'd13;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_ERR    = 2'd3
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if : instruction-memory read handshake (req/addr, ack/data).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface fetch_sequencer_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer_branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve : combinational next-PC selection from the decoder branch code.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module branch_resolve
  import cpu_pkg::*;
(
  input  wire logic [3:0]  i_brOP,
  input  wire logic [31:0] i_rs_val,
  input  wire logic [31:0] i_rt_val,
  input  wire logic [31:0] i_pc,
  input  wire logic [25:0] i_instr,
  output logic      [31:0] o_next_pc,
  output logic             o_taken
);

  logic [31:0] w_pc4;
  logic [31:0] w_bt;
  logic [31:0] w_jt;
  logic        w_rs_neg;
  logic        w_rs_zero;
  logic        w_cond;

  assign w_pc4     = i_pc + 32'd4;
  assign w_bt      = w_pc4 + {{14{i_instr[15]}}, i_instr[15:0], 2'b00};
  assign w_jt      = {w_pc4[31:28], i_instr, 2'b00};
  assign w_rs_neg  = i_rs_val[31];
  assign w_rs_zero = (i_rs_val == 32'd0);

  always_comb begin
    w_cond = 1'b0;
    case (i_brOP)
      BR_BAL, BR_B:          w_cond = 1'b1;
      BR_BGEZAL, BR_BGEZ:    w_cond = ~w_rs_neg;
      BR_BLTZ, BR_BLTZAL:    w_cond = w_rs_neg;
      BR_BEQ:                w_cond = (i_rs_val == i_rt_val);
      BR_BNE:                w_cond = (i_rs_val != i_rt_val);
      BR_BLEZ:               w_cond = w_rs_neg | w_rs_zero;
      BR_BGTZ:               w_cond = ~w_rs_neg & ~w_rs_zero;
      default:               w_cond = 1'b0;
    endcase
  end

  always_comb begin
    o_taken   = w_cond;
    o_next_pc = w_cond ? w_bt : w_pc4;
    case (i_brOP)
      BR_JR: begin
        o_taken   = 1'b1;
        o_next_pc = i_rs_val;
      end
      BR_J, BR_JAL: begin
        o_taken   = 1'b1;
        o_next_pc = w_jt;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer : PC owner, imem fetch FSM and branch resolution.
// Optional taken-redirect counter enabled by FETCH_BRANCH_STATS_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_PC,
  parameter int          ADDR_W   = 32
)(
  input  wire logic              clk,
  input  wire logic              rst,
  fetch_sequencer_if.master      imem,
  output logic [31:0]            o_instr,
  output logic [5:0]             o_opcode,
  output logic [5:0]             o_funct,
  output logic [4:0]             o_rs,
  output logic [4:0]             o_rt,
  output logic                   o_instr_valid,
  output logic [ADDR_W-1:0]      o_pc,
  output logic [ADDR_W-1:0]      o_link,
  input  wire logic              i_exec_done,
  input  wire logic [3:0]        i_brOP,
  input  wire logic [31:0]       i_rs_val,
  input  wire logic [31:0]       i_rt_val,
  output logic                   o_fetch_err,
  output logic [31:0]            o_br_taken_cnt
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic              r_valid;
  logic              r_err;
  logic [31:0]       w_next_pc;
  logic              w_taken;
  logic              w_misal;

  branch_resolve u_branch_resolve (
    .i_brOP    (i_brOP),
    .i_rs_val  (i_rs_val),
    .i_rt_val  (i_rt_val),
    .i_pc      (r_pc),
    .i_instr   (r_instr[25:0]),
    .o_next_pc (w_next_pc),
    .o_taken   (w_taken)
  );

  // Only a taken redirect can produce a misaligned target
  assign w_misal = w_taken & (w_next_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (imem.ack) begin
            r_instr <= imem.data;
            r_valid <= 1'b1;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: r_state <= ST_EXEC;
        ST_EXEC: begin
          if (i_exec_done) begin
            if (w_misal) begin
              r_err   <= 1'b1;
              r_state <= ST_ERR;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_ERR: ;
        default: r_state <= ST_ERR;
      endcase
    end
  end

  // Request gated by rst so it drops the instant reset asserts
  assign imem.req      = (r_state == ST_FETCH) & ~rst;
  assign imem.addr     = r_pc;
  assign o_instr       = r_instr;
  assign o_opcode      = r_instr[31:26];
  assign o_funct       = r_instr[5:0];
  assign o_rs          = r_instr[25:21];
  assign o_rt          = r_instr[20:16];
  assign o_instr_valid = r_valid;
  assign o_pc          = r_pc;
  assign o_link        = r_pc + 32'd4;
  assign o_fetch_err   = r_err;

`ifdef FETCH_BRANCH_STATS_EN
  logic [31:0] r_br_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_cnt <= '0;
    end else if ((r_state == ST_EXEC) && i_exec_done && !w_misal &&
                 (w_next_pc != (r_pc + 32'd4))) begin
      r_br_cnt <= r_br_cnt + 32'd1;
    end
  end

  assign o_br_taken_cnt = r_br_cnt;
`else
  assign o_br_taken_cnt = '0;
`endif

endmodule

`default_nettype wire
